tile_bag_generator: RTL and testbench

Upstream tile source for the spawn executor (executor_new). Produces a stream of playable tile types using a 7-bag randomizer driven by a free-running 16-bit LFSR. Buffers upcoming tiles in a small preview queue. Presents the queue head on a valid/ready handshake that connects directly to the executor's v_i/ready_o. Preview entries are exported for the next-piece display.

---
 rtl/tile_bag_generator.sv | 135 +++++++++++++
 tb/tb_tile_bag_generator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_bag_generator.sv
// Tile source for the spawn executor: a 7-bag randomizer fed by a free-running
// Galois LFSR, buffering drawn tiles in a preview queue behind a valid/ready head.
package tile_bag_pkg;
  typedef enum logic [2:0] {
    eNon = 3'd0, eI = 3'd1, eO = 3'd2, eT = 3'd3, eS = 3'd4, eZ = 3'd5, eJ = 3'd6, eL = 3'd7
  } tile_type_e;
endpackage

// state | meaning
// eFILL | drawing one tile per cycle into the queue
// eFULL | queue full, no draws until the head is popped
module tile_bag_generator
  import tile_bag_pkg::*;
#(
  parameter int          depth_p      = 3,
  parameter logic [15:0] seed_p       = 16'hACE1,
  parameter bit          rand_angle_p = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         seed_v_i,
  input  logic [15:0]                  seed_i,
  input  logic                         clear_i,
  output tile_type_e                   tile_type_o,
  output logic [1:0]                   tile_type_angle_o,
  output logic                         v_o,
  input  logic                         ready_i,
  output tile_type_e [depth_p-1:0]     preview_o,
  output logic [$clog2(depth_p+1)-1:0] preview_cnt_o
);
  localparam int                  cnt_w_lp    = $clog2(depth_p + 1);
  localparam logic [cnt_w_lp-1:0] depth_lp    = cnt_w_lp'(depth_p);
  localparam logic [15:0]         seed_rst_lp = (seed_p == 16'h0000) ? 16'h0001 : seed_p;

  typedef enum logic {eFILL, eFULL} state_e;

  state_e                    state_q;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [6:0]                mask_q, mask_d;
  logic [cnt_w_lp-1:0]       cnt_q, cnt_d, wr_idx;
  tile_type_e [depth_p-1:0]  type_q, type_d;
  logic [depth_p-1:0][1:0]   angle_q, angle_d;

  logic       pop, push, found;
  logic [2:0] start, sel, idx;
  logic [3:0] sum;
  logic [6:0] mask_clr;
  tile_type_e draw_type;
  logic [1:0] draw_angle;

  assign pop        = (cnt_q != '0) & ready_i;
  assign push       = (state_q == eFILL);
  assign start      = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
  assign draw_type  = tile_type_e'(sel + 3'd1);
  assign draw_angle = rand_angle_p ? lfsr_q[5:4] : 2'b00;

  assign lfsr_d = seed_v_i ? ((seed_i == 16'h0000) ? 16'h0001 : seed_i)
                           : ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000));

  // First remaining bag slot at or after start, wrapping 6 -> 0.
  always_comb begin
    sel   = start;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < 7; i++) begin
      sum = {1'b0, start} + 4'(i);
      idx = (sum >= 4'd7) ? 3'(sum - 4'd7) : sum[2:0];
      if (!found && mask_q[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    mask_clr = mask_q & ~(7'b1 << sel);
    mask_d   = (mask_clr == 7'h00) ? 7'h7F : mask_clr;
  end

  always_comb begin
    type_d  = type_q;
    angle_d = angle_q;
    if (pop) begin
      for (int i = 0; i < depth_p - 1; i++) begin
        type_d[i]  = type_q[i+1];
        angle_d[i] = angle_q[i+1];
      end
      type_d[depth_p-1]  = eNon;
      angle_d[depth_p-1] = 2'b00;
    end
    wr_idx = pop ? cnt_q - 1'b1 : cnt_q;
    for (int i = 0; i < depth_p; i++) begin
      if (push && (cnt_w_lp'(i) == wr_idx)) begin
        type_d[i]  = draw_type;
        angle_d[i] = draw_angle;
      end
    end
    cnt_d = cnt_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= eFILL;
      lfsr_q  <= seed_rst_lp;
      mask_q  <= 7'h7F;
      cnt_q   <= '0;
      angle_q <= '0;
      for (int i = 0; i < depth_p; i++) type_q[i] <= eNon;
    end else begin
      lfsr_q <= lfsr_d;
      if (clear_i) begin
        state_q <= eFILL;
        mask_q  <= 7'h7F;
        cnt_q   <= '0;
        angle_q <= '0;
        for (int i = 0; i < depth_p; i++) type_q[i] <= eNon;
      end else begin
        type_q  <= type_d;
        angle_q <= angle_d;
        cnt_q   <= cnt_d;
        if (push) mask_q <= mask_d;
        case (state_q)
          eFILL:   if (cnt_d == depth_lp) state_q <= eFULL;
          eFULL:   if (pop) state_q <= eFILL;
          default: state_q <= eFILL;
        endcase
      end
    end
  end

  assign v_o               = (cnt_q != '0);
  assign tile_type_o       = type_q[0];
  assign tile_type_angle_o = angle_q[0];
  assign preview_o         = type_q;
  assign preview_cnt_o     = cnt_q;

endmodule

// File: tb/tb_tile_bag_generator.sv
// Bench for tile_bag_generator: cycle-accurate queue/bag reference model,
// a vector table for the count/valid timeline, and directed bag sequences.
module tb_tile_bag_generator;
  import tile_bag_pkg::*;

  localparam int DEPTH = 3;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   seed_v = 1'b0;
  logic [15:0]            seed = 16'h0;
  logic                   clear = 1'b0;
  logic                   ready = 1'b0;
  tile_type_e             head;
  logic [1:0]             angle;
  logic                   v;
  tile_type_e [DEPTH-1:0] preview;
  logic [1:0]             cnt;

  tile_bag_generator #(.depth_p(DEPTH), .seed_p(16'hACE1), .rand_angle_p(1'b1)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .seed_v_i(seed_v), .seed_i(seed), .clear_i(clear),
    .tile_type_o(head), .tile_type_angle_o(angle), .v_o(v), .ready_i(ready),
    .preview_o(preview), .preview_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  tile_type_e play[7];
  logic [15:0] m_lfsr;
  bit          m_avail[7];
  tile_type_e  m_q[$];
  logic [1:0]  m_qa[$];
  tile_type_e  acc_q[$];
  tile_type_e  seq_a[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic fill_bag();
    for (int i = 0; i < 7; i++) m_avail[i] = 1'b1;
  endtask

  task automatic model_step();
    logic [15:0] nxt;
    bit          draw_now;
    int          start, k, left;
    if (!rst_n) begin
      m_lfsr = 16'hACE1;
      fill_bag();
      m_q.delete();
      m_qa.delete();
      return;
    end
    nxt = seed_v ? ((seed == 16'h0) ? 16'h0001 : seed) : lfsr_adv(m_lfsr);
    if (clear) begin
      m_q.delete();
      m_qa.delete();
      fill_bag();
    end else begin
      draw_now = (m_q.size() < DEPTH);
      if (ready && m_q.size() != 0) begin
        void'(m_q.pop_front());
        void'(m_qa.pop_front());
      end
      if (draw_now) begin
        start = (m_lfsr[2:0] == 3'd7) ? 0 : int'(m_lfsr[2:0]);
        k = -1;
        for (int i = 0; i < 7; i++)
          if (k < 0 && m_avail[(start + i) % 7]) k = (start + i) % 7;
        if (k < 0) k = 0;
        m_avail[k] = 1'b0;
        m_q.push_back(play[k]);
        m_qa.push_back(m_lfsr[5:4]);
        left = 0;
        for (int i = 0; i < 7; i++) left += int'(m_avail[i]);
        if (left == 0) fill_bag();
      end
    end
    m_lfsr = nxt;
  endtask

  task automatic compare_all();
    chk("v_o", int'(v), int'(m_q.size() != 0));
    chk("cnt", int'(cnt), m_q.size());
    chk("head", int'(head), (m_q.size() != 0) ? int'(m_q[0]) : int'(eNon));
    chk("angle", int'(angle), (m_qa.size() != 0) ? int'(m_qa[0]) : 0);
    for (int i = 0; i < DEPTH; i++)
      chk("preview", int'(preview[i]), (i < m_q.size()) ? int'(m_q[i]) : int'(eNon));
  endtask

  task automatic tick();
    if (rst_n && !clear && ready && v) acc_q.push_back(head);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic collect(input int n, input int budget);
    int c;
    c = 0;
    ready = 1'b1;
    while (acc_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("collect_budget", int'(acc_q.size() >= n), 1);
    ready = 1'b0;
  endtask

  function automatic int distinct7(input int off);
    bit seen[8];
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) seen[i] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (off + i < acc_q.size()) begin
        int t;
        t = int'(acc_q[off + i]);
        if (t != int'(eNon) && !seen[t]) begin
          seen[t] = 1'b1;
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; seed_v = 1'b0; ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic seeded_new_game(input logic [15:0] s);
    seed_v = 1'b1; seed = s; clear = 1'b1; ready = 1'b0;
    tick();
    seed_v = 1'b0; clear = 1'b0;
    acc_q.delete();
  endtask

  typedef struct {
    bit rst_n;
    bit clear;
    bit ready;
    int exp_cnt;
    bit exp_v;
  } vec_t;

  vec_t vecs[15];

  initial begin
    tile_type_e t;
    int k;
    int hist[8];
    tile_type_e snap_head;

    vecs[0]  = '{0, 0, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 1, 1};
    vecs[2]  = '{1, 0, 0, 2, 1};
    vecs[3]  = '{1, 0, 0, 3, 1};
    vecs[4]  = '{1, 0, 0, 3, 1};
    vecs[5]  = '{1, 0, 1, 2, 1};
    vecs[6]  = '{1, 0, 0, 3, 1};
    vecs[7]  = '{1, 0, 1, 2, 1};
    vecs[8]  = '{1, 0, 1, 2, 1};
    vecs[9]  = '{1, 0, 1, 2, 1};
    vecs[10] = '{1, 1, 1, 0, 0};
    vecs[11] = '{1, 0, 1, 1, 1};
    vecs[12] = '{1, 0, 1, 1, 1};
    vecs[13] = '{1, 0, 0, 2, 1};
    vecs[14] = '{0, 0, 0, 0, 0};

    // Playable types in declared enum order, skipping eNon.
    k = 0;
    t = t.first();
    for (int n = 0; n < t.num(); n++) begin
      if (t != eNon && k < 7) begin
        play[k] = t;
        k++;
      end
      t = t.next();
    end

    for (int i = 0; i < 15; i++) begin
      rst_n = vecs[i].rst_n;
      clear = vecs[i].clear;
      ready = vecs[i].ready;
      tick();
      chk("vec_cnt", int'(cnt), vecs[i].exp_cnt);
      chk("vec_v", int'(v), int'(vecs[i].exp_v));
    end

    // Reset then continuous ready: two consecutive full bags.
    do_reset();
    chk("reset_v", int'(v), 0);
    acc_q.delete();
    ready = 1'b1;
    tick();
    chk("first_v", int'(v), 1);
    collect(14, 40);
    chk("perm_bag1", distinct7(0), 7);
    chk("perm_bag2", distinct7(7), 7);

    // Stalled consumer: fill in three cycles, then hold.
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      tick();
      if (c == 3) begin
        chk("sat_cnt", int'(cnt), 3);
        snap_head = m_q[0];
      end
      if (c > 3) chk("hold_head", int'(head), int'(snap_head));
    end

    // Seeded new game is reproducible.
    seeded_new_game(16'h1234);
    collect(21, 60);
    seq_a = acc_q;
    repeat (100) tick();
    seeded_new_game(16'h1234);
    collect(21, 60);
    for (int i = 0; i < 21; i++)
      chk("seed_repeat", int'(acc_q[i]), int'(seq_a[i]));

    // Zero seed behaves as seed 1.
    seeded_new_game(16'h0000);
    collect(14, 40);
    seq_a = acc_q;
    seeded_new_game(16'h0001);
    collect(14, 40);
    for (int i = 0; i < 14; i++)
      chk("seed_zero", int'(acc_q[i]), int'(seq_a[i]));

    // Clear mid-bag refills the bag.
    do_reset();
    acc_q.delete();
    collect(4, 20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_v", int'(v), 0);
    acc_q.delete();
    collect(7, 30);
    chk("perm_after_clear", distinct7(0), 7);

    // Seventy back-to-back accepts from a fresh bag.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    acc_q.delete();
    ready = 1'b1;
    for (int c = 0; c < 71; c++) begin
      tick();
      chk("cnt_min", int'(cnt >= 2'd1), 1);
    end
    ready = 1'b0;
    chk("accept_70", acc_q.size(), 70);
    for (int i = 0; i < 8; i++) hist[i] = 0;
    for (int i = 0; i < acc_q.size() && i < 70; i++) hist[int'(acc_q[i])]++;
    for (int i = 0; i < 7; i++) chk("type_x10", hist[int'(play[i])], 10);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      rst_n  = ($urandom % 300) != 0;
      ready  = ($urandom % 4) != 0;
      clear  = ($urandom % 64) == 0;
      seed_v = ($urandom % 50) == 0;
      seed   = (($urandom % 4) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
